reg_writeback: RTL and testbench

Memory/writeback (MW) stage and register-file write side of the 3-stage RISC-V core: the writer for the decode stage's register read and MW→D forwarding. Registers the X-stage result, selects and formats the writeback value (ALU, PC+4, CSR, or aligned load data), writes the 32×32 register file, serves its two asynchronous read ports, and raises the per-operand forwarding flags for the decode stage. Also keeps a retired-instruction counter.

---
 rtl/reg_writeback.sv | 170 +++++++++++++++++
 tb/tb_reg_writeback.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: memory/writeback stage and register-file write side of the
// 3-stage RV32I core. Holds the instruction leaving X, formats its result,
// writes the 32x32 register file, serves two asynchronous read ports,
// flags MW->D forwarding and counts retired instructions.
module reg_writeback (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        x_valid,
   input  logic [31:0] x_inst,
   input  logic [31:0] x_alu,
   input  logic [31:0] x_pc4,
   input  logic [31:0] x_csr,
   input  logic [31:0] dmem_rdata,
   input  logic [31:0] d_inst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_val,
   output logic        wb2d_a,
   output logic        wb2d_b,
   output logic [31:0] instret
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Canonical NOP (addi x0, x0, 0) held in MW after reset.
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_LOAD,
      SRC_PC4,
      SRC_ALU,
      SRC_CSR
   } wb_src_t;

   // MW pipeline register
   logic        mw_valid_reg;
   logic [31:0] mw_inst_reg;
   logic [31:0] mw_alu_reg;
   logic [31:0] mw_pc4_reg;
   logic [31:0] mw_csr_reg;

   logic [31:0] instret_reg;
   logic [31:0] regs_reg [32];

   wb_src_t     wb_src;
   logic [31:0] load_val;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [7:0]  rdata_lane [4];

   logic [6:0]  mw_opcode;
   logic [2:0]  mw_funct3;
   logic [1:0]  mw_off;

   assign mw_opcode = mw_inst_reg[6:0];
   assign mw_funct3 = mw_inst_reg[14:12];
   assign mw_off    = mw_alu_reg[1:0];

   // Bits of the instruction words that this stage never looks at.
   logic unused_bits;
   assign unused_bits = &{1'b0, mw_inst_reg[31:15], d_inst[31:25], d_inst[14:0]};

   // Capture the X-stage instruction unless the pipeline is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mw_valid_reg <= 1'b0;
         mw_inst_reg  <= NOP_INST;
         mw_alu_reg   <= '0;
         mw_pc4_reg   <= '0;
         mw_csr_reg   <= '0;
      end else if (!stall) begin
         mw_valid_reg <= x_valid;
         mw_inst_reg  <= x_inst;
         mw_alu_reg   <= x_alu;
         mw_pc4_reg   <= x_pc4;
         mw_csr_reg   <= x_csr;
      end
   end

   // Count an instruction once, on the edge that moves it out of MW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_reg <= '0;
      end else if (!stall && mw_valid_reg) begin
         instret_reg <= instret_reg + 32'd1;
      end
   end

   assign instret = instret_reg;

   // Split the read word into byte lanes for offset selection.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign rdata_lane[gi] = dmem_rdata[gi*8 +: 8];
      end
   endgenerate

   // Pick the writeback source from the MW opcode.
   always_comb begin
      wb_src = SRC_NONE;
      case (mw_opcode)
         OPC_LOAD:                               wb_src = SRC_LOAD;
         OPC_JAL, OPC_JALR:                      wb_src = SRC_PC4;
         OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC:  wb_src = SRC_ALU;
         OPC_SYSTEM: begin
            // funct3 == 000 is ECALL/EBREAK/xRET: nothing to write.
            if (mw_funct3 != 3'b000) wb_src = SRC_CSR;
         end
         default:                                wb_src = SRC_NONE;
      endcase
   end

   // Align and extend the loaded byte/halfword; reserved sizes load the word.
   always_comb begin
      load_byte = rdata_lane[mw_off];
      load_half = mw_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (mw_funct3)
         3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_val = {24'h0, load_byte};
         3'b001:  load_val = {{16{load_half[15]}}, load_half};
         3'b101:  load_val = {16'h0, load_half};
         default: load_val = dmem_rdata;
      endcase
   end

   // Writeback value, enable and forwarding flags.
   always_comb begin
      case (wb_src)
         SRC_LOAD: wb_val = load_val;
         SRC_PC4:  wb_val = mw_pc4_reg;
         SRC_ALU:  wb_val = mw_alu_reg;
         SRC_CSR:  wb_val = mw_csr_reg;
         default:  wb_val = '0;
      endcase
      wb_addr = mw_inst_reg[11:7];
      wb_we   = mw_valid_reg && (wb_src != SRC_NONE) && (mw_inst_reg[11:7] != 5'd0);
      wb2d_a  = wb_we && (mw_inst_reg[11:7] == d_inst[19:15]);
      wb2d_b  = wb_we && (mw_inst_reg[11:7] == d_inst[24:20]);
   end

   // Register file write port; x0 is never selected because wb_we excludes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wb_we) begin
         regs_reg[wb_addr] <= wb_val;
      end
   end

   // Asynchronous reads without bypass: a register being written reads old
   // data until the edge; decode uses wb2d_* for the new value.
   assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs_reg[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs_reg[ra2];

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed steps followed by random traffic,
// checked every cycle against a behavioural model of the writeback stage.
module tb_reg_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        x_valid;
   logic [31:0] x_inst, x_alu, x_pc4, x_csr, dmem_rdata, d_inst;
   logic [4:0]  ra1, ra2;
   logic [31:0] rd1, rd2, wb_val, instret;
   logic        wb_we, wb2d_a, wb2d_b;
   logic [4:0]  wb_addr;

   int checks = 0;
   int errors = 0;

   // Model state: the instruction sitting in MW, the architectural
   // registers and the retired count.
   logic        m_valid;
   logic [31:0] m_inst, m_alu, m_pc4, m_csr, m_instret;
   logic [31:0] m_regs [32];

   logic [31:0] saved;

   always #5 clk = ~clk;

   reg_writeback dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .x_valid(x_valid), .x_inst(x_inst), .x_alu(x_alu), .x_pc4(x_pc4), .x_csr(x_csr),
      .dmem_rdata(dmem_rdata), .d_inst(d_inst), .ra1(ra1), .ra2(ra2),
      .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_val(wb_val),
      .wb2d_a(wb2d_a), .wb2d_b(wb2d_b), .instret(instret)
   );

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
      return {7'b0, rs2, rs1, f3, rd, opc};
   endfunction

   // Returns {writes, value} for an instruction from the ISA rules.
   function automatic logic [32:0] ref_wb(input logic [31:0] inst, input logic [31:0] alu,
                                          input logic [31:0] pc4, input logic [31:0] csr,
                                          input logic [31:0] rdata);
      logic [31:0] val, b, h;
      logic        w;
      int          off;
      off = int'(alu & 32'd3);
      b   = (rdata >> (8 * off)) & 32'hFF;
      h   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
      w   = 1'b0;
      val = 32'h0;
      case (inst[6:0])
         7'h03: begin
            w = 1'b1;
            case (inst[14:12])
               3'd0: val = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
               3'd4: val = b;
               3'd1: val = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
               3'd5: val = h;
               default: val = rdata;
            endcase
         end
         7'h6F, 7'h67: begin w = 1'b1; val = pc4; end
         7'h33, 7'h13, 7'h37, 7'h17: begin w = 1'b1; val = alu; end
         7'h73: begin w = (inst[14:12] != 3'd0); val = csr; end
         default: w = 1'b0;
      endcase
      return {w && (inst[11:7] != 5'd0), val};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_valid   = 1'b0;
      m_inst    = 32'h13;
      m_alu     = '0;
      m_pc4     = '0;
      m_csr     = '0;
      m_instret = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   // Compare every output with the model for the current inputs.
   task automatic settle();
      logic [32:0] r;
      logic        we;
      #1;
      r  = ref_wb(m_inst, m_alu, m_pc4, m_csr, dmem_rdata);
      we = m_valid && r[32];
      chk("wb_we", {31'b0, wb_we}, {31'b0, we});
      chk("wb_addr", {27'b0, wb_addr}, {27'b0, m_inst[11:7]});
      if (we) chk("wb_val", wb_val, r[31:0]);
      chk("wb2d_a", {31'b0, wb2d_a}, {31'b0, we && (m_inst[11:7] == d_inst[19:15])});
      chk("wb2d_b", {31'b0, wb2d_b}, {31'b0, we && (m_inst[11:7] == d_inst[24:20])});
      chk("rd1", rd1, m_regs[ra1]);
      chk("rd2", rd2, m_regs[ra2]);
      chk("instret", instret, m_instret);
      $display("t=%0t stall=%0b mw_inst=%h we=%0b addr=%0d val=%h instret=%0d",
               $time, stall, m_inst, wb_we, wb_addr, wb_val, instret);
   endtask

   // Apply one clock edge to the model and the DUT; returns at the next negedge.
   task automatic advance();
      logic [32:0] r;
      if (rst_n) begin
         r = ref_wb(m_inst, m_alu, m_pc4, m_csr, dmem_rdata);
         if (m_valid && r[32]) m_regs[m_inst[11:7]] = r[31:0];
         if (!stall) begin
            if (m_valid) m_instret = m_instret + 32'd1;
            m_valid = x_valid;
            m_inst  = x_inst;
            m_alu   = x_alu;
            m_pc4   = x_pc4;
            m_csr   = x_csr;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_x(input logic v, input logic [31:0] inst, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic [31:0] csr);
      x_valid = v;
      x_inst  = inst;
      x_alu   = alu;
      x_pc4   = pc4;
      x_csr   = csr;
   endtask

   task automatic drive_random();
      logic [6:0] opcs [11];
      opcs = '{7'h03, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17, 7'h73, 7'h23, 7'h63, 7'h0B};
      stall      = ($urandom_range(0, 3) == 0);
      x_valid    = ($urandom_range(0, 4) != 0);
      x_inst     = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    3'($urandom), 5'($urandom_range(0, 7)), opcs[$urandom_range(0, 10)]};
      x_alu      = $urandom;
      x_pc4      = $urandom;
      x_csr      = $urandom;
      dmem_rdata = $urandom;
      d_inst     = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    15'($urandom)};
      ra1        = 5'($urandom_range(0, 9));
      ra2        = 5'($urandom_range(0, 9));
   endtask

   logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
   logic [1:0]  ld_off [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
   logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h80FF_7F01};

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      drive_x(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      dmem_rdata = '0;
      d_inst = '0;
      ra1 = 5'd5;
      ra2 = 5'd0;
      model_reset();

      // Reset state
      @(negedge clk);
      @(negedge clk);
      settle();
      chk("rst_we", {31'b0, wb_we}, 32'd0);
      chk("rst_val", wb_val, 32'd0);
      chk("rst_instret", instret, 32'd0);
      rst_n = 1'b1;
      advance();

      // ADDI x5 and forwarding to decode rs1
      drive_x(1'b1, 32'h0010_0293, 32'h1234_5678, 32'h0, 32'h0);
      settle();
      advance();
      drive_x(1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
      d_inst = mk(7'h33, 5'd1, 3'd0, 5'd5, 5'd3);
      settle();
      chk("addi_we", {31'b0, wb_we}, 32'd1);
      chk("addi_addr", {27'b0, wb_addr}, 32'd5);
      chk("addi_val", wb_val, 32'h1234_5678);
      chk("addi_fwd", {31'b0, wb2d_a}, 32'd1);
      chk("addi_old", rd1, 32'd0);
      advance();
      settle();
      chk("addi_new", rd1, 32'h1234_5678);

      // Load formatting
      for (int i = 0; i < 5; i++) begin
         drive_x(1'b1, mk(7'h03, 5'd6, ld_f3[i], 5'd1, 5'd0), {30'h800, ld_off[i]}, 32'h0, 32'h0);
         settle();
         advance();
         drive_x(1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
         dmem_rdata = 32'h80FF_7F01;
         settle();
         chk("load_val", wb_val, ld_exp[i]);
         advance();
      end

      // JAL x1 writes PC+4; JAL x0 writes nothing
      drive_x(1'b1, 32'h0000_00EF, 32'h0, 32'h0000_1004, 32'h0);
      settle();
      advance();
      drive_x(1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
      settle();
      chk("jal_val", wb_val, 32'h0000_1004);
      advance();
      ra1 = 5'd1;
      settle();
      chk("jal_x1", rd1, 32'h0000_1004);
      drive_x(1'b1, 32'h0000_006F, 32'h0, 32'h0000_2008, 32'h0);
      advance();
      drive_x(1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
      settle();
      chk("jal0_we", {31'b0, wb_we}, 32'd0);
      advance();
      ra1 = 5'd0;
      settle();
      chk("x0_zero", rd1, 32'd0);

      // STORE and BRANCH with rd field 7 write nothing but still retire
      d_inst = mk(7'h33, 5'd1, 3'd0, 5'd7, 5'd7);
      ra1 = 5'd7;
      for (int i = 0; i < 2; i++) begin
         drive_x(1'b1, mk((i == 0) ? 7'h23 : 7'h63, 5'd7, 3'd2, 5'd7, 5'd7),
                 32'hDEAD_BEE0, 32'h0, 32'h0);
         advance();
         saved = instret;
         drive_x(1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
         settle();
         chk("nowr_we", {31'b0, wb_we}, 32'd0);
         chk("nowr_fwd", {30'b0, wb2d_a, wb2d_b}, 32'd0);
         advance();
         settle();
         chk("nowr_x7", rd1, 32'd0);
         chk("nowr_ret", instret, saved + 32'd1);
      end

      // Stall three cycles on a valid ADD
      drive_x(1'b1, mk(7'h33, 5'd9, 3'd0, 5'd1, 5'd2), 32'hCAFE_BABE, 32'h0, 32'h0);
      advance();
      saved = instret;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) stall = 1'b0;
         drive_x(1'b1, $urandom, $urandom, $urandom, $urandom);
         settle();
         chk("stall_val", wb_val, 32'hCAFE_BABE);
         chk("stall_we", {31'b0, wb_we}, 32'd1);
         chk("stall_ret", instret, saved);
         advance();
      end
      chk("stall_ret1", instret, saved + 32'd1);

      // Counter wrap
      drive_x(1'b1, mk(7'h13, 5'd4, 3'd0, 5'd0, 5'd0), 32'h4, 32'h0, 32'h0);
      advance();
      force dut.instret_reg = 32'hFFFF_FFFF;
      #1;
      release dut.instret_reg;
      m_instret = 32'hFFFF_FFFF;
      settle();
      advance();
      settle();
      chk("wrap", instret, 32'd0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         drive_random();
         settle();
         advance();
      end

      // Reset mid-run, then a little more traffic
      ra1 = 5'd5;
      #2;
      rst_n = 1'b0;
      model_reset();
      settle();
      chk("mrst_we", {31'b0, wb_we}, 32'd0);
      chk("mrst_instret", instret, 32'd0);
      chk("mrst_rd1", rd1, 32'd0);
      advance();
      rst_n = 1'b1;
      for (int n = 0; n < 100; n++) begin
         drive_random();
         settle();
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
